// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exec_sequencer
// Purpose  : Multicycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for ControlUnit,
//            producing one-cycle Datapath enables with ready timeouts.
// Revision : 1.0
// ============================================================================
module exec_sequencer #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic             fetch_ready,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_wr_rd,
  input  logic             dec_is_branch,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             ir_en,
  output logic             alu_en,
  output logic             mem_req,
  output logic             mem_we,
  output logic             rf_wr_en,
  output logic             pc_en,
  output logic             pc_branch,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  localparam logic [WAIT_W-1:0] c_max_wait = WAIT_W'(MAX_WAIT);

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_wait;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_fault;
  logic                r_ld, r_st, r_wr, r_br, r_br_tk;
  logic                w_retire;
  logic                w_wait_clr;
  logic                w_wait_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_cnt   <= '0;
      r_fault <= 1'b0;
      r_ld    <= 1'b0;
      r_st    <= 1'b0;
      r_wr    <= 1'b0;
      r_br    <= 1'b0;
      r_br_tk <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_FAULT)
        r_fault <= 1'b1;
      if (w_wait_clr)
        r_wait <= '0;
      else if (w_wait_inc)
        r_wait <= r_wait + 1'b1;
      if (r_state == S_DECODE) begin
        r_ld <= dec_is_load;
        r_st <= dec_is_store;
        r_wr <= dec_wr_rd;
        r_br <= dec_is_branch;
      end
      if (r_state == S_EXECUTE)
        r_br_tk <= r_br & branch_taken;
      if (w_retire)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    w_wait_clr = 1'b0;
    w_wait_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next     = S_FETCH;
          w_wait_clr = 1'b1;
        end
      end
      S_FETCH: begin
        // A ready arriving on the last tolerated cycle still wins.
        if (fetch_ready)
          w_next = S_DECODE;
        else if (r_wait == c_max_wait)
          w_next = S_FAULT;
        else
          w_wait_inc = 1'b1;
      end
      S_DECODE: w_next = S_EXECUTE;
      S_EXECUTE: begin
        if (r_ld && r_st)
          w_next = S_FAULT;
        else if (r_ld || r_st) begin
          w_next     = S_MEM;
          w_wait_clr = 1'b1;
        end else if (r_wr)
          w_next = S_WB;
        else
          w_retire = 1'b1;
      end
      S_MEM: begin
        if (mem_ready) begin
          if (r_ld)
            w_next = S_WB;
          else
            w_retire = 1'b1;
        end else if (r_wait == c_max_wait)
          w_next = S_FAULT;
        else
          w_wait_inc = 1'b1;
      end
      S_WB:    w_retire = 1'b1;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FAULT;
    endcase
    if (w_retire) begin
      w_next     = halt_req ? S_IDLE : S_FETCH;
      w_wait_clr = ~halt_req;
    end
  end

  // The branch flag is live in EXECUTE and only registered for later retires.
  assign pc_branch = w_retire & ((r_state == S_EXECUTE) ? (r_br & branch_taken) : r_br_tk);
  assign pc_en     = w_retire;
  assign ir_en     = (r_state == S_FETCH) & fetch_ready;
  assign alu_en    = (r_state == S_EXECUTE);
  assign mem_req   = (r_state == S_MEM);
  assign mem_we    = (r_state == S_MEM) & r_st;
  assign rf_wr_en  = (r_state == S_WB);
  assign busy      = (r_state != S_IDLE) && (r_state != S_FAULT);
  assign fault     = r_fault;
  assign state     = r_state;
  assign instr_cnt = r_cnt;

endmodule
`default_nettype wire

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multicycle instruction sequencer inside ControlUnit.
- Steps the Datapath through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and generates the one-cycle enables the Datapath consumes: ir_en, alu_en, the memory handshake, rf_wr_en (drives Datapath wr_en) and pc_en.
- Handles ready handshakes with timeout, halt, fault and retired-instruction counting.

Parameters:
- MAX_WAIT, 15: maximum consecutive not-ready cycles tolerated in FETCH or MEM before FAULT.
- WAIT_W, 4: width of wait counter; must hold MAX_WAIT.
- CNT_W, 8: width of retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin execution from IDLE; ignored otherwise.
- halt_req  in  1  level; sampled at retire; return to IDLE instead of FETCH.
- fetch_ready  in  1  instruction memory has valid word.
- dec_is_load  in  1  decoder: load; sampled in DECODE.
- dec_is_store  in  1  decoder: store; sampled in DECODE.
- dec_wr_rd  in  1  decoder: writes destination register; sampled in DECODE.
- dec_is_branch  in  1  decoder: branch; sampled in DECODE.
- branch_taken  in  1  ALU flag result; sampled in EXECUTE.
- mem_ready  in  1  data memory completes access.
- ir_en  out  1  load instruction register.
- alu_en  out  1  ALU operation strobe.
- mem_req  out  1  data memory request.
- mem_we  out  1  data memory write qualifier.
- rf_wr_en  out  1  register-file write (Datapath wr_en).
- pc_en  out  1  PC update strobe.
- pc_branch  out  1  PC select branch target (valid with pc_en).
- busy  out  1  state is not IDLE and not FAULT.
- fault  out  1  sticky fault flag.
- state  out  3  current state encoding.
- instr_cnt  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, FAULT=6. Codes 7 and up are illegal and go to FAULT.
- Reset (async): state=IDLE, instr_cnt=0, fault=0, wait counter=0, decode latches=0. All strobes drop immediately, including mid-MEM; no pending access is completed.
- Registered: state, instr_cnt, fault, wait counter, decode latches (ld, st, wr, br), br_tk.
- Strobe decode (combinational):
  - ir_en = FETCH & fetch_ready.
  - alu_en = EXECUTE.
  - mem_req = MEM.
  - mem_we = MEM & st.
  - rf_wr_en = WB.
- IDLE: if start, go to FETCH.
- FETCH: if fetch_ready, go to DECODE. Otherwise increment the wait counter; if the counter is already MAX_WAIT, go to FAULT. A ready in the same cycle wins over the timeout.
- DECODE: latch dec_* inputs; go to EXECUTE.
- EXECUTE:
  - If ld and st are both set, go to FAULT (no alu_en side effect is required to be suppressed).
  - If ld or st, go to MEM.
  - Else if wr, go to WB.
  - Else retire.
  - Latch br_tk = br & branch_taken.
- MEM: hold mem_req, and mem_we if store, until mem_ready. Then a load goes to WB and a store retires. Same timeout rule as FETCH. The wait counter clears on every entry to FETCH or MEM.
- WB: single cycle; then retire.
- Retire (exit cycle of EXECUTE, MEM or WB):
  - pc_en=1 and pc_branch=br_tk for that cycle.
  - instr_cnt increments; 2^CNT_W-1 wraps to 0.
  - Next state is IDLE if halt_req, else FETCH.
- Loads always write back regardless of dec_wr_rd. Stores never write back.
- FAULT: all strobes 0, fault=1, busy=0. Held until rst; start is ignored.
- Latency in cycles, ready asserted immediately:
  - ALU op with no destination: 3.
  - ALU op with destination: 4.
  - Store: 4.
  - Load: 5.
  - Each not-ready cycle adds 1.
- start asserted while busy and halt_req asserted in IDLE have no effect.
- Exactly one of ir_en, alu_en, mem_req, rf_wr_en is high in any cycle, or none.

Test Plan:
- Reset then start pulse; ALU op with dec_wr_rd=1, all readies high: states 1,2,3,5 then FETCH. rf_wr_en high exactly in cycle 4, pc_en in cycle 4, instr_cnt=1.
- Load with mem_ready delayed 3 cycles: mem_req high 4 cycles, mem_we=0, then WB. rf_wr_en once, instr_cnt increments once, total 8 cycles.
- Store with mem_ready immediate: mem_we=1 for one cycle, rf_wr_en never, pc_en on the MEM exit cycle. Taken branch (dec_is_branch=1, branch_taken=1, no rd): pc_en and pc_branch=1 in the EXECUTE cycle.
- fetch_ready held low with MAX_WAIT=15: FAULT entered after the 16th not-ready cycle, fault=1 sticky; start is ignored; rst clears to IDLE.
- dec_is_load=dec_is_store=1: FAULT from EXECUTE, no mem_req. Separately, assert rst mid-MEM: mem_req drops asynchronously and state=0.
- halt_req=1 during WB: retire, then IDLE with busy=0. Run 256 instructions with CNT_W=8: instr_cnt wraps to 0.
